// File: rtl/xgriscv_hazard_unit_pkg.sv
// rtl/xgriscv_hazard_unit_pkg.sv - shared defines for the xgriscv hazard unit
package xgriscv_hazard_unit_pkg;

    localparam logic [1:0] FWD_RF = 2'b00;
    localparam logic [1:0] FWD_M  = 2'b01;
    localparam logic [1:0] FWD_W  = 2'b10;

    localparam int MC_LAT_DEFAULT = 4;

    typedef enum logic [1:0] {
        ACT_NORMAL,
        ACT_LOADUSE,
        ACT_REDIRECT,
        ACT_BUSY
    } hz_action_e;

    // The M stage wins over W because it holds the younger result.
    function automatic logic [1:0] fwd_sel(input logic m_hit, input logic w_hit);
        logic [1:0] sel;
        if (m_hit) begin
            sel = FWD_M;
        end else if (w_hit) begin
            sel = FWD_W;
        end else begin
            sel = FWD_RF;
        end
        return sel;
    endfunction

endpackage

// File: rtl/xgriscv_hazard_unit_hz_match.sv
// rtl/xgriscv_hazard_unit_hz_match.sv - writer-vs-source tag comparator
// x0 and bubbles never match, so callers need no extra qualification.
module hz_match
    import xgriscv_hazard_unit_pkg::*;
#(
    parameter int RFIDX_WIDTH = 5
) (
    input  logic                   valid_i,
    input  logic                   regwrite_i,
    input  logic [RFIDX_WIDTH-1:0] rd_i,
    input  logic [RFIDX_WIDTH-1:0] rs_i,
    input  logic                   use_i,
    output logic                   match_o
);

    assign match_o = valid_i & regwrite_i & use_i & (rd_i != '0) & (rd_i == rs_i);

endmodule

// File: rtl/xgriscv_hazard_unit.sv
// rtl/xgriscv_hazard_unit.sv - stall/flush/forward control for the five-stage xgriscv core
// Tracks E/M/W destination tags itself and holds multi-cycle ops in E for MC_LAT cycles.
module xgriscv_hazard_unit
    import xgriscv_hazard_unit_pkg::*;
#(
    parameter int RFIDX_WIDTH = 5,
    parameter int MC_LAT      = MC_LAT_DEFAULT,
    parameter int CNT_W       = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [RFIDX_WIDTH-1:0] rs1D,
    input  logic [RFIDX_WIDTH-1:0] rs2D,
    input  logic                   use1D,
    input  logic                   use2D,
    input  logic [RFIDX_WIDTH-1:0] rdD,
    input  logic                   regwriteD,
    input  logic                   loadD,
    input  logic                   mcopD,
    input  logic                   redirectE,
    output logic                   stallF,
    output logic                   stallD,
    output logic                   flushD,
    output logic                   flushE,
    output logic                   stallE,
    output logic                   bubbleM,
    output logic [1:0]             fwdaE,
    output logic [1:0]             fwdbE,
    output logic                   wbbypass1D,
    output logic                   wbbypass2D
);

    logic                   e_valid_q, e_regwrite_q, e_load_q, e_mc_q, e_use1_q, e_use2_q;
    logic                   e_valid_d, e_regwrite_d, e_load_d, e_mc_d, e_use1_d, e_use2_d;
    logic [RFIDX_WIDTH-1:0] e_rd_q, e_rs1_q, e_rs2_q, e_rd_d, e_rs1_d, e_rs2_d;
    logic                   m_valid_q, m_regwrite_q, m_load_q, m_valid_d, m_regwrite_d, m_load_d;
    logic [RFIDX_WIDTH-1:0] m_rd_q, m_rd_d;
    logic                   w_valid_q, w_regwrite_q, w_valid_d, w_regwrite_d;
    logic [RFIDX_WIDTH-1:0] w_rd_q, w_rd_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;

    logic lu1_hit, lu2_hit, fa_m_hit, fa_w_hit, fb_m_hit, fb_w_hit, bp1_hit, bp2_hit;
    logic load_use, busy, run;
    hz_action_e action;

    hz_match #(.RFIDX_WIDTH(RFIDX_WIDTH)) u_lu1 (
        .valid_i(e_valid_q), .regwrite_i(e_regwrite_q), .rd_i(e_rd_q),
        .rs_i(rs1D), .use_i(use1D), .match_o(lu1_hit));
    hz_match #(.RFIDX_WIDTH(RFIDX_WIDTH)) u_lu2 (
        .valid_i(e_valid_q), .regwrite_i(e_regwrite_q), .rd_i(e_rd_q),
        .rs_i(rs2D), .use_i(use2D), .match_o(lu2_hit));
    hz_match #(.RFIDX_WIDTH(RFIDX_WIDTH)) u_fa_m (
        .valid_i(m_valid_q), .regwrite_i(m_regwrite_q), .rd_i(m_rd_q),
        .rs_i(e_rs1_q), .use_i(e_use1_q), .match_o(fa_m_hit));
    hz_match #(.RFIDX_WIDTH(RFIDX_WIDTH)) u_fa_w (
        .valid_i(w_valid_q), .regwrite_i(w_regwrite_q), .rd_i(w_rd_q),
        .rs_i(e_rs1_q), .use_i(e_use1_q), .match_o(fa_w_hit));
    hz_match #(.RFIDX_WIDTH(RFIDX_WIDTH)) u_fb_m (
        .valid_i(m_valid_q), .regwrite_i(m_regwrite_q), .rd_i(m_rd_q),
        .rs_i(e_rs2_q), .use_i(e_use2_q), .match_o(fb_m_hit));
    hz_match #(.RFIDX_WIDTH(RFIDX_WIDTH)) u_fb_w (
        .valid_i(w_valid_q), .regwrite_i(w_regwrite_q), .rd_i(w_rd_q),
        .rs_i(e_rs2_q), .use_i(e_use2_q), .match_o(fb_w_hit));
    hz_match #(.RFIDX_WIDTH(RFIDX_WIDTH)) u_bp1 (
        .valid_i(w_valid_q), .regwrite_i(w_regwrite_q), .rd_i(w_rd_q),
        .rs_i(rs1D), .use_i(use1D), .match_o(bp1_hit));
    hz_match #(.RFIDX_WIDTH(RFIDX_WIDTH)) u_bp2 (
        .valid_i(w_valid_q), .regwrite_i(w_regwrite_q), .rd_i(w_rd_q),
        .rs_i(rs2D), .use_i(use2D), .match_o(bp2_hit));

    assign load_use = e_load_q & (lu1_hit | lu2_hit);
    assign busy     = e_mc_q & (cnt_q != '0);
    assign run      = ~reset;

    always_comb begin
        if (busy) begin
            action = ACT_BUSY;
        end else if (redirectE) begin
            action = ACT_REDIRECT;
        end else if (load_use) begin
            action = ACT_LOADUSE;
        end else begin
            action = ACT_NORMAL;
        end
    end

    assign stallF     = run & ((action == ACT_BUSY) | (action == ACT_LOADUSE));
    assign stallD     = stallF;
    assign stallE     = run & (action == ACT_BUSY);
    assign bubbleM    = stallE;
    assign flushD     = run & (action == ACT_REDIRECT);
    assign flushE     = run & ((action == ACT_REDIRECT) | (action == ACT_LOADUSE));
    // A load in M has no data yet; it is picked up from W one cycle later.
    assign fwdaE      = run ? fwd_sel(fa_m_hit & ~m_load_q, fa_w_hit) : FWD_RF;
    assign fwdbE      = run ? fwd_sel(fb_m_hit & ~m_load_q, fb_w_hit) : FWD_RF;
    assign wbbypass1D = run & bp1_hit;
    assign wbbypass2D = run & bp2_hit;

    always_comb begin
        e_valid_d    = 1'b1;
        e_rd_d       = rdD;
        e_regwrite_d = regwriteD;
        e_load_d     = loadD;
        e_mc_d       = mcopD;
        e_rs1_d      = rs1D;
        e_rs2_d      = rs2D;
        e_use1_d     = use1D;
        e_use2_d     = use2D;
        m_valid_d    = e_valid_q;
        m_rd_d       = e_rd_q;
        m_regwrite_d = e_regwrite_q;
        m_load_d     = e_load_q;
        w_valid_d    = m_valid_q;
        w_rd_d       = m_rd_q;
        w_regwrite_d = m_regwrite_q;
        cnt_d        = cnt_q;

        unique case (action)
            ACT_BUSY: begin
                e_valid_d    = e_valid_q;
                e_rd_d       = e_rd_q;
                e_regwrite_d = e_regwrite_q;
                e_load_d     = e_load_q;
                e_mc_d       = e_mc_q;
                e_rs1_d      = e_rs1_q;
                e_rs2_d      = e_rs2_q;
                e_use1_d     = e_use1_q;
                e_use2_d     = e_use2_q;
                m_valid_d    = 1'b0;
                m_rd_d       = '0;
                m_regwrite_d = 1'b0;
                m_load_d     = 1'b0;
                cnt_d        = cnt_q - CNT_W'(1);
            end
            ACT_REDIRECT, ACT_LOADUSE: begin
                e_valid_d    = 1'b0;
                e_rd_d       = '0;
                e_regwrite_d = 1'b0;
                e_load_d     = 1'b0;
                e_mc_d       = 1'b0;
                e_rs1_d      = '0;
                e_rs2_d      = '0;
                e_use1_d     = 1'b0;
                e_use2_d     = 1'b0;
            end
            default: begin
                if (mcopD) begin
                    cnt_d = CNT_W'(MC_LAT - 1);
                end
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            e_valid_q    <= 1'b0;
            e_rd_q       <= '0;
            e_regwrite_q <= 1'b0;
            e_load_q     <= 1'b0;
            e_mc_q       <= 1'b0;
            e_rs1_q      <= '0;
            e_rs2_q      <= '0;
            e_use1_q     <= 1'b0;
            e_use2_q     <= 1'b0;
            m_valid_q    <= 1'b0;
            m_rd_q       <= '0;
            m_regwrite_q <= 1'b0;
            m_load_q     <= 1'b0;
            w_valid_q    <= 1'b0;
            w_rd_q       <= '0;
            w_regwrite_q <= 1'b0;
            cnt_q        <= '0;
        end else begin
            e_valid_q    <= e_valid_d;
            e_rd_q       <= e_rd_d;
            e_regwrite_q <= e_regwrite_d;
            e_load_q     <= e_load_d;
            e_mc_q       <= e_mc_d;
            e_rs1_q      <= e_rs1_d;
            e_rs2_q      <= e_rs2_d;
            e_use1_q     <= e_use1_d;
            e_use2_q     <= e_use2_d;
            m_valid_q    <= m_valid_d;
            m_rd_q       <= m_rd_d;
            m_regwrite_q <= m_regwrite_d;
            m_load_q     <= m_load_d;
            w_valid_q    <= w_valid_d;
            w_rd_q       <= w_rd_d;
            w_regwrite_q <= w_regwrite_d;
            cnt_q        <= cnt_d;
        end
    end

endmodule

// File: tb/tb_xgriscv_hazard_unit.sv
// tb/tb_xgriscv_hazard_unit.sv - self-checking bench for xgriscv_hazard_unit
module tb_xgriscv_hazard_unit;

    logic       clk = 1'b0;
    logic       reset;
    logic [4:0] rs1D, rs2D, rdD;
    logic       use1D, use2D, regwriteD, loadD, mcopD, redirectE;
    logic       stallF, stallD, flushD, flushE, stallE, bubbleM;
    logic [1:0] fwdaE, fwdbE;
    logic       wbbypass1D, wbbypass2D;

    xgriscv_hazard_unit #(.RFIDX_WIDTH(5), .MC_LAT(4), .CNT_W(4)) dut (
        .clk(clk), .reset(reset),
        .rs1D(rs1D), .rs2D(rs2D), .use1D(use1D), .use2D(use2D), .rdD(rdD),
        .regwriteD(regwriteD), .loadD(loadD), .mcopD(mcopD), .redirectE(redirectE),
        .stallF(stallF), .stallD(stallD), .flushD(flushD), .flushE(flushE),
        .stallE(stallE), .bubbleM(bubbleM), .fwdaE(fwdaE), .fwdbE(fwdbE),
        .wbbypass1D(wbbypass1D), .wbbypass2D(wbbypass2D)
    );

    always #5 clk = ~clk;

    typedef struct {
        string      name;
        logic       rst;
        logic [4:0] rs1;
        logic       u1;
        logic [4:0] rs2;
        logic       u2;
        logic [4:0] rd;
        logic       rw, ld, mc, redir;
        logic [11:0] exp;
    } vec_t;

    typedef struct {
        string       name;
        logic [11:0] exp;
    } sb_t;

    sb_t  sb_q[$];
    int   errors = 0;
    int   checks = 0;
    vec_t tbl[13];

    logic [11:0] act;
    assign act = {stallF, stallD, stallE, bubbleM, flushD, flushE, fwdaE, fwdbE, wbbypass1D, wbbypass2D};

    function automatic logic [11:0] ex(logic st, logic se, logic fd, logic fe,
                                       logic [1:0] fa, logic [1:0] fb, logic b1, logic b2);
        return {st, st, se, se, fd, fe, fa, fb, b1, b2};
    endfunction

    function automatic vec_t mk(string n, logic rst, logic [4:0] rs1, logic u1, logic [4:0] rs2,
                                logic u2, logic [4:0] rd, logic rw, logic ld, logic mc,
                                logic redir, logic [11:0] e);
        vec_t v;
        v.name = n; v.rst = rst; v.rs1 = rs1; v.u1 = u1; v.rs2 = rs2; v.u2 = u2;
        v.rd = rd; v.rw = rw; v.ld = ld; v.mc = mc; v.redir = redir; v.exp = e;
        return v;
    endfunction

    task automatic check_out();
        sb_t s;
        checks++;
        if (sb_q.size() == 0) begin
            errors++;
            $display("FAIL scoreboard_empty: got %b required an expected entry", act);
        end else begin
            s = sb_q.pop_front();
            if (act !== s.exp) begin
                errors++;
                $display("FAIL %s: got %b required %b (sF sD sE bM fD fE fa fb b1 b2)",
                         s.name, act, s.exp);
            end
        end
    endtask

    task automatic step(input vec_t v);
        sb_t s;
        reset = v.rst; rs1D = v.rs1; use1D = v.u1; rs2D = v.rs2; use2D = v.u2;
        rdD = v.rd; regwriteD = v.rw; loadD = v.ld; mcopD = v.mc; redirectE = v.redir;
        s.name = v.name;
        s.exp  = v.exp;
        sb_q.push_back(s);
        @(negedge clk);
        check_out();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout required completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset = 1'b1;
        rs1D = '0; rs2D = '0; rdD = '0;
        use1D = 1'b0; use2D = 1'b0; regwriteD = 1'b0; loadD = 1'b0; mcopD = 1'b0; redirectE = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;

        step(mk("reset_forces_zero", 1, 5, 1, 5, 1, 5, 1, 1, 1, 1, ex(0, 0, 0, 0, 2'b00, 2'b00, 0, 0)));

        tbl[0]  = mk("lw_x5_enter",       0,  1, 1, 0, 0,  5, 1, 1, 0, 0, ex(0, 0, 0, 0, 2'b00, 2'b00, 0, 0));
        tbl[1]  = mk("load_use",          0,  5, 1, 2, 1,  7, 1, 0, 0, 0, ex(1, 0, 0, 1, 2'b00, 2'b00, 0, 0));
        tbl[2]  = mk("load_use_release",  0,  5, 1, 2, 1,  7, 1, 0, 0, 0, ex(0, 0, 0, 0, 2'b00, 2'b00, 0, 0));
        tbl[3]  = mk("load_fwd_w",        0,  7, 1, 5, 1,  6, 1, 0, 0, 0, ex(0, 0, 0, 0, 2'b10, 2'b00, 0, 1));
        tbl[4]  = mk("alu_fwd_m",         0,  0, 1, 0, 0,  6, 1, 0, 0, 0, ex(0, 0, 0, 0, 2'b01, 2'b00, 0, 0));
        tbl[5]  = mk("x0_src",            0,  0, 1, 6, 1,  9, 1, 0, 0, 0, ex(0, 0, 0, 0, 2'b00, 2'b00, 0, 0));
        tbl[6]  = mk("m_over_w",          0,  6, 1, 0, 0,  0, 1, 0, 0, 0, ex(0, 0, 0, 0, 2'b00, 2'b01, 1, 0));
        tbl[7]  = mk("w_fwd",             0,  0, 1, 0, 0, 10, 1, 0, 0, 0, ex(0, 0, 0, 0, 2'b10, 2'b00, 0, 0));
        tbl[8]  = mk("x0_writer_in_m",    0,  0, 1, 0, 0, 11, 1, 0, 0, 0, ex(0, 0, 0, 0, 2'b00, 2'b00, 0, 0));
        tbl[9]  = mk("x0_writer_in_w",    0,  0, 1, 0, 0, 12, 1, 1, 0, 0, ex(0, 0, 0, 0, 2'b00, 2'b00, 0, 0));
        tbl[10] = mk("redirect_over_lu",  0, 12, 1, 0, 0, 13, 1, 0, 0, 1, ex(0, 0, 1, 1, 2'b00, 2'b00, 0, 0));
        tbl[11] = mk("post_redirect",     0, 12, 1, 0, 0, 13, 1, 0, 0, 0, ex(0, 0, 0, 0, 2'b00, 2'b00, 0, 0));
        tbl[12] = mk("post_redirect_fwd", 0,  0, 0, 0, 0,  0, 0, 0, 0, 0, ex(0, 0, 0, 0, 2'b10, 2'b00, 0, 0));

        for (int i = 0; i < 13; i++) begin
            step(tbl[i]);
        end

        step(mk("mc_enter",          0, 13, 1, 0, 0, 14, 1, 0, 1, 0, ex(0, 0, 0, 0, 2'b00, 2'b00, 0, 0)));
        step(mk("mc_busy1",          0, 14, 1, 0, 0, 15, 1, 0, 0, 0, ex(1, 1, 0, 0, 2'b10, 2'b00, 0, 0)));
        step(mk("mc_busy2_redirect", 0, 14, 1, 0, 0, 15, 1, 0, 0, 1, ex(1, 1, 0, 0, 2'b00, 2'b00, 0, 0)));
        step(mk("mc_busy3",          0, 14, 1, 0, 0, 15, 1, 0, 0, 0, ex(1, 1, 0, 0, 2'b00, 2'b00, 0, 0)));
        step(mk("mc_advance_b2b",    0, 14, 1, 0, 0, 16, 1, 0, 1, 0, ex(0, 0, 0, 0, 2'b00, 2'b00, 0, 0)));
        step(mk("b2b_busy1",         0, 16, 1, 0, 0, 17, 1, 0, 0, 0, ex(1, 1, 0, 0, 2'b01, 2'b00, 0, 0)));
        step(mk("reset_in_busy2",    1, 16, 1, 0, 0, 17, 1, 0, 0, 0, ex(0, 0, 0, 0, 2'b00, 2'b00, 0, 0)));
        step(mk("post_reset_dep",    0, 16, 1, 0, 0, 17, 1, 0, 0, 0, ex(0, 0, 0, 0, 2'b00, 2'b00, 0, 0)));
        step(mk("post_reset_normal", 0,  0, 0, 0, 0,  0, 0, 0, 0, 0, ex(0, 0, 0, 0, 2'b00, 2'b00, 0, 0)));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/xgriscv_hazard_unit.md
# xgriscv_hazard_unit

Pipeline hazard controller for the five-stage xgriscv core: generates fetch/decode stalls, decode/execute flushes, E-stage operand forwarding selects and a W→D write-through bypass. It keeps its own shadow of in-flight destination tags for E, M and W, so the datapath needs no separate hazard bookkeeping. Beyond plain load-use and redirect handling, it also holds multi-cycle execute ops (mul/div class) in E for a parametrised latency, inserting bubbles into M.

## Interface
- RFIDX_WIDTH, 5, register index width
- MC_LAT, 4, cycles a multi-cycle op occupies E (legal range 2..16)
- CNT_W, 4, width of the multi-cycle counter; must satisfy 2^CNT_W > MC_LAT-1

Ports:
- clk  in  1  core clock
- reset  in  1  asynchronous, active-high
- rs1D, rs2D  in  RFIDX_WIDTH  D-stage source indices
- use1D, use2D  in  1  D instruction actually reads rs1/rs2
- rdD  in  RFIDX_WIDTH  D-stage destination
- regwriteD, loadD, mcopD  in  1  D writes rd / is a load / is multi-cycle
- redirectE  in  1  branch taken or jump resolved in E
- stallF, stallD  out  1  hold PC and the IF/ID register
- flushD  out  1  clear the IF/ID register
- flushE  out  1  insert a bubble into ID/EX
- stallE  out  1  hold ID/EX (multi-cycle op busy)
- bubbleM  out  1  insert a bubble into EX/MEM
- fwdaE, fwdbE  out  2  operand source: 00 regfile, 01 M aluout, 10 W wdata
- wbbypass1D, wbbypass2D  out  1  D read uses wdataW instead of the regfile

## Operation
- Shadow state:
  - E holds valid, rd, regwrite, load, mc, rs1, rs2, use1, use2.
  - M holds valid, rd, regwrite, load.
  - W holds valid, rd, regwrite.
- Normal cycle: D→E, E→M, M→W on every edge.
- A bubble is valid=0 with all other fields 0.
- A "match" requires the writer's regwrite=1, valid=1, rd≠0, and rd equal to the compared rs with its use bit set. x0 never matches.
- Load-use: the E shadow is a load and matches rs1D or rs2D.
  - Response: stallF=stallD=1, flushE=1 for one cycle.
- Multi-cycle:
  - When an mc op enters E, cnt loads MC_LAT-1; cnt decrements each cycle while nonzero.
  - busy = mcE & (cnt≠0).
  - While busy: stallF=stallD=stallE=1 and bubbleM=1. The E shadow holds; M receives a bubble; M→W advances.
- Redirect (redirectE=1, not busy): flushD=flushE=1 and stallF=stallD=0.
  - Redirect overrides load-use.
  - The PC loads the target.
- Priority, highest first:
  1. busy
  2. redirect
  3. load-use
- redirectE asserted while busy is ignored; mc ops never redirect.
- Forwarding for E operand a:
  - 01 if M matches rs1E and M is not a load.
  - Else 10 if W matches rs1E.
  - Else 00.
  - fwdbE is the same using rs2E.
  - M has priority over W.
- wbbypass1D/2D = 1 when W matches rs1D/rs2D. This covers regfile write-then-read in the same cycle.

## Timing
- All outputs are combinational from the shadow state and the current D/E inputs; the stall decision takes effect at the next edge. No added latency.
- Reset: asserting reset clears all shadows to bubbles and cnt to 0, and forces every output to 0 while reset is high.
- Reset mid multi-cycle op: the op is discarded and cnt=0; the first cycle after release is a normal cycle.
- An mc op occupies E for exactly MC_LAT cycles: cnt=MC_LAT-1 down to 0, then it advances.
- Load-use costs exactly 1 bubble; after it, the load is in W and the consumer receives fwd=10.
- A back-to-back mc op entering E as the previous one leaves reloads cnt; there is no gap cycle.
- A load in E with a dependent in D while redirectE=1: only the flush occurs; the dependent is discarded.

## Structure
- Fwd select encodings (FWD_RF, FWD_M, FWD_W) go in the shared defines file.
- MC_LAT default also goes in the shared defines file.
- One sub-module, hz_match: a combinational writer-vs-source comparator including the x0 and valid checks.
  - Instanced for load-use (×2), forwarding (×4) and the W bypass (×2).

## Test plan
- Load-use: lw x5 in E, D uses rs1=x5 → one cycle of stallF=stallD=flushE=1; the next cycle has fwdaE=10.
- ALU chain: add x6 in M, D-then-E consumer rs2=x6 → fwdbE=01. The same rd in both M and W → 01 wins.
- x0 writer: rd=0 with regwrite in M, consumer reads x0 → fwdaE=00, no stall.
- Multi-cycle, MC_LAT=4: mul enters E → stallE=bubbleM=1 for 3 cycles, then it advances. redirectE pulsed mid-busy is ignored.
- Redirect with concurrent load-use → flushD=flushE=1, stallF=0; no bubble counted twice.
- Reset asserted in the 2nd busy cycle → all outputs 0 immediately. After release, a dependent with no writer in flight gives fwd=00 and no stall.
